// File: rtl/exe_stage.sv
// Execute stage: ALU, iterative restoring divider and data-SRAM request issue.
// Optional EXE_DIV_EARLY_OUT_EN lets a divide with |dividend| < |divisor| finish without BUSY.
module exe_stage #(
    parameter int unsigned DIV_BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         id_to_exe_valid,
    input  logic [242:0] id_to_exe_bus,
    output logic         exe_allowin,
    input  logic         mem_allowin,
    output logic         exe_to_mem_valid,
    output logic [159:0] exe_to_mem_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         gr_we_exe,
    output logic [4:0]   dest_exe,
    output logic [31:0]  forward_data_exe,
    output logic         exe_ld,
    output logic         exe_csr_re,
    input  logic         mem_ex,
    input  logic         wb_ex
);
    localparam int unsigned DivCycles = 32 / DIV_BITS_PER_CYCLE;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    div_state_e   state_q, state_d;
    logic         exe_valid_q, exe_valid_d;
    logic [242:0] bus_q, bus_d;
    logic [31:0]  dvd_q, dvd_d, rem_q, rem_d, dsr_q, dsr_d, res_q, res_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         neg_q_q, neg_q_d, neg_r_q, neg_r_d, want_q_q, want_q_d;

    // Passthru side-band: pc [31:0], dest [36:32], gr_we [37], load [38], csr_re [39];
    // bit 15 flags a syscall.
    logic [3:0]   div_op;
    logic [2:0]   store_op;
    logic [11:0]  alu_op;
    logic [31:0]  src1, src2, rkd;
    logic [127:0] passthru;
    assign {div_op, store_op, alu_op, src1, src2, rkd, passthru} = bus_q;

    logic [31:0] alu_result;
    always_comb begin
        logic [31:0] sra_res;
        sra_res    = 32'($signed(src1) >>> src2[4:0]);
        alu_result = ({32{alu_op[0]}}  & (src1 + src2))
                   | ({32{alu_op[1]}}  & (src1 - src2))
                   | ({32{alu_op[2]}}  & {31'b0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[3]}}  & {31'b0, src1 < src2})
                   | ({32{alu_op[4]}}  & (src1 & src2))
                   | ({32{alu_op[5]}}  & ~(src1 | src2))
                   | ({32{alu_op[6]}}  & (src1 | src2))
                   | ({32{alu_op[7]}}  & (src1 ^ src2))
                   | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
                   | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
                   | ({32{alu_op[10]}} & sra_res)
                   | ({32{alu_op[11]}} & src2);
    end

    logic is_div, signed_op, s1_neg, s2_neg;
    logic [31:0] s1_abs, s2_abs;
    assign is_div    = |div_op;
    assign signed_op = div_op[0] | div_op[1];
    assign s1_neg    = signed_op & src1[31];
    assign s2_neg    = signed_op & src2[31];
    assign s1_abs    = s1_neg ? -src1 : src1;
    assign s2_abs    = s2_neg ? -src2 : src2;

    // N restoring steps: dividend shifts out the top while quotient bits shift in below.
    logic [31:0] dvd_n, rem_n;
    always_comb begin
        logic [32:0] trial;
        dvd_n = dvd_q;
        rem_n = rem_q;
        trial = '0;
        for (int unsigned i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
            trial = {rem_n, dvd_n[31]};
            dvd_n = {dvd_n[30:0], 1'b0};
            if (trial >= {1'b0, dsr_q}) begin
                trial    = trial - {1'b0, dsr_q};
                dvd_n[0] = 1'b1;
            end
            rem_n = trial[31:0];
        end
    end

    logic exe_ready_go, early_out;
    assign exe_ready_go     = !is_div || (state_q == StDone);
    assign exe_allowin      = !exe_valid_q || (exe_ready_go && mem_allowin);
    assign exe_to_mem_valid = exe_valid_q && exe_ready_go;

`ifdef EXE_DIV_EARLY_OUT_EN
    assign early_out = (s2_abs != '0) && (s1_abs < s2_abs);
`else
    assign early_out = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        want_q_d    = want_q_q;
        exe_valid_d = exe_valid_q;
        bus_d       = bus_q;
        if (wb_ex) begin
            exe_valid_d = 1'b0;
        end else if (exe_allowin) begin
            exe_valid_d = id_to_exe_valid;
        end
        if (id_to_exe_valid && exe_allowin) begin
            bus_d = id_to_exe_bus;
        end
        if (wb_ex) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (exe_valid_q && is_div) begin
                        dvd_d    = s1_abs;
                        rem_d    = '0;
                        dsr_d    = s2_abs;
                        cnt_d    = '0;
                        want_q_d = div_op[0] | div_op[2];
                        // A zero divisor yields all-ones regardless of signs.
                        neg_q_d  = (s1_neg ^ s2_neg) && (src2 != '0);
                        neg_r_d  = s1_neg;
                        if (early_out) begin
                            res_d   = (div_op[0] | div_op[2]) ? '0 : src1;
                            state_d = StDone;
                        end else begin
                            state_d = StBusy;
                        end
                    end
                end
                StBusy: begin
                    dvd_d = dvd_n;
                    rem_d = rem_n;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(DivCycles - 1)) begin
                        res_d   = want_q_q ? (neg_q_q ? -dvd_n : dvd_n)
                                           : (neg_r_q ? -rem_n : rem_n);
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (exe_to_mem_valid && mem_allowin) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            exe_valid_q <= 1'b0;
            bus_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            want_q_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            exe_valid_q <= exe_valid_d;
            bus_q       <= bus_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            want_q_q    <= want_q_d;
        end
    end

    logic [31:0] exe_result;
    logic [3:0]  we_raw;
    logic        load_op;
    assign exe_result = is_div ? res_q : alu_result;
    assign load_op    = passthru[38];

    always_comb begin
        we_raw          = 4'h0;
        data_sram_wdata = rkd;
        if (store_op[0]) begin
            we_raw          = 4'b0001 << alu_result[1:0];
            data_sram_wdata = {4{rkd[7:0]}};
        end else if (store_op[1]) begin
            we_raw          = 4'b0011 << {alu_result[1], 1'b0};
            data_sram_wdata = {2{rkd[15:0]}};
        end else if (store_op[2]) begin
            we_raw = 4'hF;
        end
    end

    assign data_sram_en     = exe_valid_q && exe_ready_go && mem_allowin
                           && (load_op || (|store_op)) && !mem_ex && !wb_ex && !passthru[15];
    assign data_sram_we     = data_sram_en ? we_raw : 4'h0;
    assign data_sram_addr   = alu_result;
    assign exe_to_mem_bus   = {passthru[127:32], exe_result, passthru[31:0]};
    assign gr_we_exe        = passthru[37] && exe_valid_q;
    assign dest_exe         = exe_valid_q ? passthru[36:32] : 5'd0;
    assign forward_data_exe = exe_valid_q ? exe_result : 32'd0;
    assign exe_ld           = load_op && exe_valid_q;
    assign exe_csr_re       = passthru[39] && exe_valid_q;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: vector table, hand sequences and random ops against a reference model.
module tb_exe_stage;
    localparam int unsigned N = 1;

    logic         clk = 1'b0;
    logic         resetn;
    logic         id_to_exe_valid;
    logic [242:0] id_to_exe_bus;
    logic         exe_allowin;
    logic         mem_allowin;
    logic         exe_to_mem_valid;
    logic [159:0] exe_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         gr_we_exe;
    logic [4:0]   dest_exe;
    logic [31:0]  forward_data_exe;
    logic         exe_ld;
    logic         exe_csr_re;
    logic         mem_ex;
    logic         wb_ex;

    exe_stage #(.DIV_BITS_PER_CYCLE(N)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .id_to_exe_valid  (id_to_exe_valid),
        .id_to_exe_bus    (id_to_exe_bus),
        .exe_allowin      (exe_allowin),
        .mem_allowin      (mem_allowin),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .gr_we_exe        (gr_we_exe),
        .dest_exe         (dest_exe),
        .forward_data_exe (forward_data_exe),
        .exe_ld           (exe_ld),
        .exe_csr_re       (exe_csr_re),
        .mem_ex           (mem_ex),
        .wb_ex            (wb_ex)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_pt(input logic csr, input logic ld, input logic grwe,
                                           input logic [4:0] dest, input logic [31:0] pc);
        return {88'h00C0FFEE, csr, ld, grwe, dest, pc};
    endfunction

    function automatic logic [242:0] mk_bus(input logic [3:0] dop, input logic [2:0] sop,
                                            input logic [11:0] aop, input logic [31:0] s1,
                                            input logic [31:0] s2, input logic [31:0] rkd,
                                            input logic [127:0] pt);
        return {dop, sop, aop, s1, s2, rkd, pt};
    endfunction

    // op: 0 div.w, 1 mod.w, 2 div.wu, 3 mod.wu
    function automatic logic [31:0] div_model(input int op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q, r;
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op >= 2) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return (op == 0 || op == 2) ? q : r;
    endfunction

    function automatic int lat_model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        bit early;
        ma = (op < 2 && a[31]) ? -longint'($signed(a)) : longint'(a);
        mb = (op < 2 && b[31]) ? -longint'($signed(b)) : longint'(b);
        early = 0;
`ifdef EXE_DIV_EARLY_OUT_EN
        early = (mb != 0) && (ma < mb);
`endif
        return early ? 1 : 32 / N + 1;
    endfunction

    function automatic logic [31:0] alu_model(input int k, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return sa >>> b[4:0];
            default: return b;
        endcase
    endfunction

    // Presents one instruction and returns #1 after the accepting edge (cycle 0).
    task automatic issue(input logic [242:0] b);
        bit ok;
        id_to_exe_bus   = b;
        id_to_exe_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exe_allowin) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue: exe_allowin got 0, expected 1");
        end
        @(posedge clk);
        #1 id_to_exe_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] res, output int lat, output logic [159:0] bo);
        lat = -1;
        res = '0;
        bo  = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exe_to_mem_valid) begin
                lat = k;
                res = exe_to_mem_bus[63:32];
                bo  = exe_to_mem_bus;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string name, input int op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        logic [31:0]  res;
        int           lat;
        logic [159:0] bo;
        issue(mk_bus(4'b0001 << op, 3'b000, 12'h000, a, b, 32'h0,
                     mk_pt(1'b0, 1'b0, 1'b1, 5'd3, 32'h1C00_0100)));
        wait_done(res, lat, bo);
        chk({name, " result"}, 96'(res), 96'(exp));
        chk({name, " latency"}, 96'(lat), 96'(lat_model(op, a, b)));
    endtask

    typedef struct {
        int          op;
        logic [11:0] aop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0]  res;
        logic [31:0]  exp;
        logic [127:0] pt;
        logic [159:0] bo;
        int           lat, explat, en_cnt;

        tbl[0]  = '{0, 12'h000, 32'd100, 32'd7, 32'd14};
        tbl[1]  = '{1, 12'h000, -32'sd100, 32'd7, 32'hFFFF_FFFE};
        tbl[2]  = '{0, 12'h000, -32'sd100, 32'd7, 32'hFFFF_FFF2};
        tbl[3]  = '{0, 12'h000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[4]  = '{1, 12'h000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        tbl[5]  = '{2, 12'h000, 32'd5, 32'd0, 32'hFFFF_FFFF};
        tbl[6]  = '{3, 12'h000, 32'd5, 32'd0, 32'd5};
        tbl[7]  = '{2, 12'h000, 32'd3, 32'd8, 32'd0};
        tbl[8]  = '{3, 12'h000, 32'd3, 32'd8, 32'd3};
        tbl[9]  = '{0, 12'h000, 32'd9, 32'd3, 32'd3};
        tbl[10] = '{1, 12'h000, 32'd7, -32'sd3, 32'd1};
        tbl[11] = '{0, 12'h000, -32'sd7, 32'd0, 32'hFFFF_FFFF};
        tbl[12] = '{1, 12'h000, -32'sd7, 32'd0, 32'hFFFF_FFF9};
        tbl[13] = '{-1, 12'h001, 32'd5, 32'd7, 32'd12};
        tbl[14] = '{-1, 12'h002, 32'd3, 32'd5, 32'hFFFF_FFFE};

        resetn          = 1'b0;
        id_to_exe_valid = 1'b0;
        id_to_exe_bus   = '0;
        mem_allowin     = 1'b1;
        mem_ex          = 1'b0;
        wb_ex           = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst exe_allowin", 96'(exe_allowin), 96'd1);
        chk("rst to_mem_valid", 96'(exe_to_mem_valid), 96'd0);
        chk("rst to_mem_bus", 96'(exe_to_mem_bus[159:64] | exe_to_mem_bus[63:0]), 96'd0);
        chk("rst sram", 96'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}), 96'd0);
        chk("rst hazard", 96'({gr_we_exe, dest_exe, forward_data_exe, exe_ld, exe_csr_re}), 96'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].op >= 0) begin
                run_div($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
            end else begin
                issue(mk_bus(4'h0, 3'b000, tbl[i].aop, tbl[i].a, tbl[i].b, 32'h0,
                             mk_pt(1'b0, 1'b0, 1'b1, 5'd1, 32'h1C00_0000)));
                wait_done(res, lat, bo);
                chk($sformatf("tbl%0d alu result", i), 96'(res), 96'(tbl[i].exp));
                chk($sformatf("tbl%0d alu latency", i), 96'(lat), 96'd0);
            end
        end

        // st.b to 0x1003
        issue(mk_bus(4'h0, 3'b001, 12'h001, 32'h1000, 32'h3, 32'h0000_00AB,
                     mk_pt(1'b0, 1'b0, 1'b0, 5'd0, 32'h1C00_0010)));
        @(negedge clk);
        chk("st.b en", 96'(data_sram_en), 96'd1);
        chk("st.b we", 96'(data_sram_we), 96'(4'b1000));
        chk("st.b wdata", 96'(data_sram_wdata), 96'(32'hABAB_ABAB));
        chk("st.b addr", 96'(data_sram_addr), 96'(32'h1003));
        @(posedge clk);
        #1;

        issue(mk_bus(4'h0, 3'b010, 12'h001, 32'h1000, 32'h2, 32'h5555_1234,
                     mk_pt(1'b0, 1'b0, 1'b0, 5'd0, 32'h1C00_0014)));
        @(negedge clk);
        chk("st.h we", 96'(data_sram_we), 96'(4'b1100));
        chk("st.h wdata", 96'(data_sram_wdata), 96'(32'h1234_1234));
        @(posedge clk);
        #1;

        // ld.w with hazard side-band
        issue(mk_bus(4'h0, 3'b000, 12'h001, 32'h2000, 32'h4, 32'h0,
                     mk_pt(1'b1, 1'b1, 1'b1, 5'd7, 32'h1C00_0018)));
        @(negedge clk);
        chk("ld.w en", 96'(data_sram_en), 96'd1);
        chk("ld.w we", 96'(data_sram_we), 96'd0);
        chk("ld.w addr", 96'(data_sram_addr), 96'(32'h2004));
        chk("ld.w hazard", 96'({gr_we_exe, dest_exe, exe_ld, exe_csr_re}), 96'({1'b1, 5'd7, 2'b11}));
        chk("ld.w forward", 96'(forward_data_exe), 96'(32'h2004));
        @(posedge clk);
        #1;

        mem_ex = 1'b1;
        issue(mk_bus(4'h0, 3'b100, 12'h001, 32'h3000, 32'h0, 32'h1,
                     mk_pt(1'b0, 1'b0, 1'b0, 5'd0, 32'h1C00_001C)));
        @(negedge clk);
        chk("st mem_ex en", 96'(data_sram_en), 96'd0);
        @(posedge clk);
        #1 mem_ex = 1'b0;

        issue(mk_bus(4'h0, 3'b100, 12'h001, 32'h3000, 32'h0, 32'h1,
                     mk_pt(1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_8000)));
        @(negedge clk);
        chk("st syscall en", 96'(data_sram_en), 96'd0);
        @(posedge clk);
        #1;

        // Stalled store: no request until mem_allowin rises, then exactly one.
        mem_allowin = 1'b0;
        issue(mk_bus(4'h0, 3'b100, 12'h001, 32'h3000, 32'h4, 32'h1,
                     mk_pt(1'b0, 1'b0, 1'b0, 5'd0, 32'h1C00_0020)));
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en_cnt += int'(data_sram_en);
        end
        chk("stall en count", 96'(en_cnt), 96'd0);
        chk("stall allowin", 96'(exe_allowin), 96'd0);
        @(posedge clk);
        #1 mem_allowin = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en_cnt += int'(data_sram_en);
        end
        chk("release en count", 96'(en_cnt), 96'd1);
        @(posedge clk);
        #1;

        // wb_ex in cycle 10 of a divide.
        issue(mk_bus(4'b0001, 3'b000, 12'h000, 32'd100, 32'd7, 32'h0,
                     mk_pt(1'b0, 1'b0, 1'b1, 5'd4, 32'h1C00_0024)));
        repeat (10) @(posedge clk);
        #1 wb_ex = 1'b1;
        @(posedge clk);
        #1 wb_ex = 1'b0;
        chk("wb_ex to_mem_valid", 96'(exe_to_mem_valid), 96'd0);
        chk("wb_ex allowin", 96'(exe_allowin), 96'd1);
        chk("wb_ex hazard", 96'({gr_we_exe, dest_exe, forward_data_exe}), 96'd0);
        run_div("after wb_ex div.w 9,3", 0, 32'd9, 32'd3, 32'd3);

        // Reset mid-BUSY.
        issue(mk_bus(4'b0001, 3'b000, 12'h000, 32'd100, 32'd7, 32'h0,
                     mk_pt(1'b0, 1'b0, 1'b1, 5'd4, 32'h1C00_0028)));
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst allowin", 96'(exe_allowin), 96'd1);
        chk("midrst outputs", 96'({exe_to_mem_valid, data_sram_en, data_sram_we, gr_we_exe,
                                   dest_exe, exe_ld, exe_csr_re, forward_data_exe}), 96'd0);
        chk("midrst bus", 96'(exe_to_mem_bus[159:64] | exe_to_mem_bus[63:0]), 96'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_div("after reset div.w 9,3", 0, 32'd9, 32'd3, 32'd3);

        for (int it = 0; it < 30; it++) begin
            logic [31:0] a, b;
            logic [3:0]  dop;
            logic [11:0] aop;
            int          sel, ai;
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 20);
            pt = {$urandom, $urandom, $urandom, $urandom};
            if (sel < 4) begin
                dop    = 4'b0001 << sel;
                aop    = 12'h000;
                exp    = div_model(sel, a, b);
                explat = lat_model(sel, a, b);
            end else begin
                ai     = $urandom_range(0, 11);
                dop    = 4'h0;
                aop    = 12'h001 << ai;
                exp    = alu_model(ai, a, b);
                explat = 0;
            end
            issue(mk_bus(dop, 3'b000, aop, a, b, $urandom, pt));
            wait_done(res, lat, bo);
            chk($sformatf("rand%0d result", it), 96'(res), 96'(exp));
            chk($sformatf("rand%0d latency", it), 96'(lat), 96'(explat));
            chk($sformatf("rand%0d passthru", it), bo[159:64], pt[127:32]);
            chk($sformatf("rand%0d pc", it), 96'(bo[31:0]), 96'(pt[31:0]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
